pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 24 ++
 rtl/pc_gen_if.sv | 49 ++++
 rtl/pc_redirect_q.sv | 103 ++++++++++
 rtl/pc_gen.sv | 104 ++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_pkg
//  Description : Shared definitions for the program-counter generator:
//                FSM state encoding, chip-enable constants and the default
//                reset vector / sequential step.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

  // Two-state fetch FSM: IDLE holds ce low, FETCH issues requests.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } pc_state_e;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam int          DEFAULT_STEP      = 4;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_if
//  Description : Fetch-side bundle of the program-counter generator.
//                The master modport is taken by pc_gen (it originates fetch
//                requests); the slave modport is for the pipeline / memory.
//  Ports       : stall_i, branch_flag_i, branch_target_i, gnt_i   -> pc_gen
//                exc_flag_i, exc_target_i (only with PC_EXC_EN)  -> pc_gen
//                ce, req_o, pc, addr_err_o                       <- pc_gen
//  Macro       : PC_EXC_EN adds the exception redirect signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
  parameter int ADDR_W = 32
) ();

  logic              stall_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
`ifdef PC_EXC_EN
  logic              exc_flag_i;
  logic [ADDR_W-1:0] exc_target_i;
`endif
  logic              gnt_i;
  logic              ce;
  logic              req_o;
  logic [ADDR_W-1:0] pc;
  logic              addr_err_o;

  modport master (
    input  stall_i, branch_flag_i, branch_target_i,
`ifdef PC_EXC_EN
    input  exc_flag_i, exc_target_i,
`endif
    input  gnt_i,
    output ce, req_o, pc, addr_err_o
  );

  modport slave (
    output stall_i, branch_flag_i, branch_target_i,
`ifdef PC_EXC_EN
    output exc_flag_i, exc_target_i,
`endif
    output gnt_i,
    input  ce, req_o, pc, addr_err_o
  );

endinterface : pc_gen_if
`default_nettype wire

// File: rtl/pc_redirect_q.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect_q
//  Description : Single-entry pending redirect register. Merges the redirect
//                arriving this cycle with the one already pending and
//                presents the effective redirect to the PC register.
//                Exceptions beat branches, both same-cycle and against a
//                pending entry; otherwise the newer redirect wins.
//  Ports       : clk, rst (async, active-low)
//                i_active        - FSM in FETCH; redirects are ignored else
//                i_fire          - PC advances this cycle; pending clears
//                i_br_flag/_target, i_exc_flag/_target (PC_EXC_EN)
//                o_valid/o_target - effective redirect (aligned)
//                o_addr_err      - misaligned target captured last cycle
//  Macro       : PC_EXC_EN enables the exception input pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_q #(
  parameter int ADDR_W = 32,
  parameter int STEP   = 4
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              i_active,
  input  wire              i_fire,
  input  wire              i_br_flag,
  input  wire [ADDR_W-1:0] i_br_target,
`ifdef PC_EXC_EN
  input  wire              i_exc_flag,
  input  wire [ADDR_W-1:0] i_exc_target,
`endif
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_target,
  output logic              o_addr_err
);

  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(STEP - 1);

  logic              r_pend_valid;
  logic              r_pend_exc;
  logic [ADDR_W-1:0] r_pend_target;
  logic              r_addr_err;

  logic              w_in_valid;
  logic              w_in_exc;
  logic [ADDR_W-1:0] w_in_raw;
  logic [ADDR_W-1:0] w_in_target;
  logic              w_in_misaligned;
  logic              w_take_in;

  // Select this cycle's incoming redirect; exception has priority.
  always_comb begin
    w_in_valid = 1'b0;
    w_in_exc   = 1'b0;
    w_in_raw   = '0;
    if (i_active) begin
`ifdef PC_EXC_EN
      if (i_exc_flag) begin
        w_in_valid = 1'b1;
        w_in_exc   = 1'b1;
        w_in_raw   = i_exc_target;
      end else
`endif
      if (i_br_flag) begin
        w_in_valid = 1'b1;
        w_in_raw   = i_br_target;
      end
    end
  end

  assign w_in_target     = w_in_raw & ~c_ALIGN_MASK;
  assign w_in_misaligned = |(w_in_raw & c_ALIGN_MASK);

  // A branch may not displace a pending exception; everything else replaces
  // whatever is pending.
  assign w_take_in = w_in_valid & ~(r_pend_valid & r_pend_exc & ~w_in_exc);

  assign o_valid    = w_take_in | r_pend_valid;
  assign o_target   = w_take_in ? w_in_target : r_pend_target;
  assign o_addr_err = r_addr_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_valid  <= 1'b0;
      r_pend_exc    <= 1'b0;
      r_pend_target <= '0;
      r_addr_err    <= 1'b0;
    end else begin
      r_addr_err <= w_take_in & w_in_misaligned;
      if (i_fire) begin
        // Consumed now (either the incoming or the pending target).
        r_pend_valid <= 1'b0;
        r_pend_exc   <= 1'b0;
      end else if (w_take_in) begin
        r_pend_valid  <= 1'b1;
        r_pend_exc    <= w_in_exc;
        r_pend_target <= w_in_target;
      end
    end
  end

endmodule : pc_redirect_q
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Instruction-fetch program-counter generator. After reset
//                it issues sequential fetches from RESET_VEC in steps of
//                STEP bytes, advancing only when the request is granted and
//                the pipeline is not stalled. Branch (and optionally
//                exception) redirects are queued in pc_redirect_q and take
//                effect on the next advance; the fetch at the redirect-cycle
//                PC (delay slot) is not suppressed.
//  Ports       : clk, rst (async, active-low)
//                bus (pc_gen_if.master): stall_i, branch_flag_i,
//                branch_target_i, [exc_flag_i, exc_target_i], gnt_i,
//                ce, req_o, pc, addr_err_o
//  Macro       : PC_EXC_EN enables exception redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                STEP      = DEFAULT_STEP,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC)
) (
  input wire        clk,
  input wire        rst,
  pc_gen_if.master  bus
);

  localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(STEP);

  pc_state_e         r_state;
  pc_state_e         w_state_nxt;
  logic              w_ce;
  logic              w_fire;
  logic [ADDR_W-1:0] r_pc;
  logic              w_redir_valid;
  logic [ADDR_W-1:0] w_redir_target;
  logic              w_addr_err;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ce        = ChipDisable;
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        w_state_nxt = FETCH;
        w_ce        = ChipEnable;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_fire = w_ce & bus.gnt_i & ~bus.stall_i;

  // ---------------- pending redirect ----------------
  pc_redirect_q #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_redirect_q (
    .clk          (clk),
    .rst          (rst),
    .i_active     (w_ce),
    .i_fire       (w_fire),
    .i_br_flag    (bus.branch_flag_i),
    .i_br_target  (bus.branch_target_i),
`ifdef PC_EXC_EN
    .i_exc_flag   (bus.exc_flag_i),
    .i_exc_target (bus.exc_target_i),
`endif
    .o_valid      (w_redir_valid),
    .o_target     (w_redir_target),
    .o_addr_err   (w_addr_err)
  );

  // ---------------- PC register ----------------
  // IDLE pins the PC to RESET_VEC so the first FETCH cycle presents it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_VEC;
    end else if (r_state == IDLE) begin
      r_pc <= RESET_VEC;
    end else if (w_fire) begin
      r_pc <= w_redir_valid ? w_redir_target : (r_pc + c_STEP);
    end
  end

  assign bus.ce         = w_ce;
  assign bus.req_o      = w_ce;
  assign bus.pc         = r_pc;
  assign bus.addr_err_o = w_addr_err;

endmodule : pc_gen
`default_nettype wire
